// File: rtl/tile_scratchpad.sv
// Multi-port wide-word scratchpad: round-robin arbitrated BANDWIDTH-lane reads with
// pipelined latency, plus a masked wide write. Optional bounds check: SCRATCHPAD_BOUNDS_CHECK_EN.
module tile_scratchpad #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BANDWIDTH  = 4,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned RD_LATENCY = 1,
  localparam int unsigned PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int unsigned LW        = BANDWIDTH * DATA_WIDTH
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            rd_req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_PORTS-1:0]            rd_grant,
  output logic                            rd_valid,
  output logic [PW-1:0]                   rd_port,
  output logic [LW-1:0]                   rd_data,
  input  logic                            wr_en,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [LW-1:0]                   wr_data,
  input  logic [BANDWIDTH-1:0]            wr_mask,
  output logic                            oob
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]         ptr_q;
  logic [PW-1:0]         cand_c;
  logic [PW-1:0]         grant_id_c;
  logic                  grant_any_c;
  logic [ADDR_WIDTH-1:0] rd_base_c;

  logic [BANDWIDTH-1:0][ADDR_WIDTH-1:0] rd_idx_c;
  logic [BANDWIDTH-1:0][ADDR_WIDTH-1:0] wr_idx_c;
  logic [BANDWIDTH-1:0]                 rd_ovf_c;
  logic [BANDWIDTH-1:0]                 wr_ovf_c;
  logic [BANDWIDTH-1:0]                 wr_lane_en_c;
  logic [LW-1:0]                        fetch_c;

  logic [RD_LATENCY-1:0]           vld_q;
  logic [RD_LATENCY-1:0][PW-1:0]   port_q;
  logic [RD_LATENCY-1:0][LW-1:0]   data_q;

  // Round-robin arbiter: first requester at or after ptr wins
  always_comb begin
    rd_grant    = '0;
    grant_any_c = 1'b0;
    grant_id_c  = '0;
    cand_c      = '0;
    if (!reset) begin
      for (int off = 0; off < int'(NUM_PORTS); off++) begin
        cand_c = PW'((32'(ptr_q) + 32'(off)) % NUM_PORTS);
        if (!grant_any_c && rd_req[cand_c]) begin
          grant_any_c      = 1'b1;
          grant_id_c       = cand_c;
          rd_grant[cand_c] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (grant_any_c) begin
      ptr_q <= (32'(grant_id_c) == NUM_PORTS - 1) ? '0 : grant_id_c + 1'b1;
    end
  end

  assign rd_base_c = rd_addr[32'(grant_id_c) * ADDR_WIDTH +: ADDR_WIDTH];

  // Per-lane word addresses; overflow only tracked when bounds checking is built in
  for (genvar g = 0; g < int'(BANDWIDTH); g++) begin : g_lane
`ifdef SCRATCHPAD_BOUNDS_CHECK_EN
    logic [ADDR_WIDTH:0] rsum;
    logic [ADDR_WIDTH:0] wsum;
    assign rsum        = {1'b0, rd_base_c} + (ADDR_WIDTH+1)'(g);
    assign wsum        = {1'b0, wr_addr} + (ADDR_WIDTH+1)'(g);
    assign rd_idx_c[g] = rsum[ADDR_WIDTH-1:0];
    assign wr_idx_c[g] = wsum[ADDR_WIDTH-1:0];
    assign rd_ovf_c[g] = rsum[ADDR_WIDTH];
    assign wr_ovf_c[g] = wsum[ADDR_WIDTH];
`else
    assign rd_idx_c[g] = rd_base_c + ADDR_WIDTH'(g);
    assign wr_idx_c[g] = wr_addr + ADDR_WIDTH'(g);
    assign rd_ovf_c[g] = 1'b0;
    assign wr_ovf_c[g] = 1'b0;
`endif
    assign wr_lane_en_c[g] = wr_mask[g] & ~wr_ovf_c[g];
    assign fetch_c[g*DATA_WIDTH +: DATA_WIDTH] = rd_ovf_c[g] ? '0 : mem[rd_idx_c[g]];
  end

  // Storage is never reset; NBA write keeps same-cycle reads read-first
  always_ff @(posedge clock) begin
    if (wr_en && !reset) begin
      for (int i = 0; i < int'(BANDWIDTH); i++) begin
        if (wr_lane_en_c[i]) begin
          mem[wr_idx_c[i]] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Read pipeline; idle stages carry zero so outputs are clean when not valid
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q  <= '0;
      port_q <= '0;
      data_q <= '0;
    end else begin
      vld_q[0]  <= grant_any_c;
      port_q[0] <= grant_any_c ? grant_id_c : '0;
      data_q[0] <= grant_any_c ? fetch_c : '0;
      for (int k = 1; k < int'(RD_LATENCY); k++) begin
        vld_q[k]  <= vld_q[k-1];
        port_q[k] <= port_q[k-1];
        data_q[k] <= data_q[k-1];
      end
    end
  end

  assign rd_valid = vld_q[RD_LATENCY-1];
  assign rd_port  = port_q[RD_LATENCY-1];
  assign rd_data  = data_q[RD_LATENCY-1];

`ifdef SCRATCHPAD_BOUNDS_CHECK_EN
  logic [RD_LATENCY-1:0] oob_q;
  logic                  wr_oob_q;

  // Read flag travels with its response; write flag is raised the cycle after
  always_ff @(posedge clock) begin
    if (reset) begin
      oob_q    <= '0;
      wr_oob_q <= 1'b0;
    end else begin
      oob_q[0] <= grant_any_c & (|rd_ovf_c);
      for (int k = 1; k < int'(RD_LATENCY); k++) begin
        oob_q[k] <= oob_q[k-1];
      end
      wr_oob_q <= wr_en & (|wr_ovf_c);
    end
  end

  assign oob = oob_q[RD_LATENCY-1] | wr_oob_q;
`else
  assign oob = 1'b0;
`endif

endmodule

// File: doc/tile_scratchpad.md
# tile_scratchpad

Parametrised, multi-port, wide-word read memory that feeds operand tiles to the systolic array driver and its successors. Serves one BANDWIDTH-lane read per cycle, arbitrated round-robin across NUM_PORTS requesters, with a configurable pipelined read latency. Adds a masked wide write port so result tiles can be written back. Replaces the single-port, fixed-latency, read-only operand memory used with the current driver.

## Interface
- DATA_WIDTH, 32: bits per lane (fp32 word).
- BANDWIDTH, 4: lanes per access.
- DEPTH, 256: words of storage; power of two, ≥ BANDWIDTH.
- ADDR_WIDTH, $clog2(DEPTH): word address width.
- NUM_PORTS, 2: read requesters, 1..8.
- RD_LATENCY, 1: cycles from grant to rd_valid, 1..4.
- PW, max(1, $clog2(NUM_PORTS)): port-id width (derived).

- clock  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- rd_req  in  NUM_PORTS  per-port read request.
- rd_addr  in  NUM_PORTS×ADDR_WIDTH  per-port base word address.
- rd_grant  out  NUM_PORTS  one-hot, combinational; request accepted this cycle.
- rd_valid  out  1  response valid.
- rd_port  out  PW  port id of the response.
- rd_data  out  BANDWIDTH×DATA_WIDTH  lane i = word base+i.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  base word address.
- wr_data  in  BANDWIDTH×DATA_WIDTH  lane i → word wr_addr+i.
- wr_mask  in  BANDWIDTH  per-lane write enable.
- oob  out  1  out-of-range flag (see Configuration).

## Operation
- Arbiter: at most one grant per cycle; round-robin starting at pointer ptr (reset 0). Grant goes to the first requesting port at or after ptr; ptr then becomes granted+1 mod NUM_PORTS. No request → ptr unchanged, no grant.
- Requesters hold rd_req/rd_addr until granted; an ungranted request is not stored.
- Read: granted base captured, fetch pipelined through RD_LATENCY stages with port id; one new read per cycle, no bubbles.
- Lane address = (base+i) mod DEPTH (wrap) unless bounds check is enabled.
- Write: for each i with wr_mask[i]=1, word (wr_addr+i) mod DEPTH ← lane i at posedge. wr_mask=0 is a no-op.
- Read/write collision on the same word in the same cycle: read returns old data (read-first).
- rd_data and rd_port are zero whenever rd_valid=0.
- Memory contents are not cleared by reset and are X after power-up.

## Timing
- Grant in cycle t → rd_valid=1 during cycle t+RD_LATENCY, for exactly one cycle per grant.
- Write at edge t visible to reads granted in cycle t+1 onward.
- Reset values: rd_valid 0, rd_data 0, rd_port 0, oob 0, ptr 0; rd_grant is 0 while reset=1.
- Reset during operation: all in-flight reads are dropped and never produce rd_valid; a write in the reset cycle is ignored.
- Throughput: 1 read + 1 write per cycle, sustained.

## Configuration
- SCRATCHPAD_BOUNDS_CHECK_EN defined: an access with base+BANDWIDTH > DEPTH does not wrap.
  - Read: overflowing lanes return 0, and oob=1 together with that response's rd_valid.
  - Write: overflowing lanes are dropped, and oob=1 in the cycle after the write.
  - In-range lanes behave normally.
- Not defined: addresses wrap modulo DEPTH; oob is tied to 0.

## Test plan
Bench: DEPTH=16, BANDWIDTH=4, NUM_PORTS=2, RD_LATENCY=2.
- Write addr 0, mask 4'hF, lanes {1.0,2.0,3.0,4.0}; port 0 reads addr 0 at cycle t → rd_valid at t+2, rd_port=0, lanes 3F800000/40000000/40400000/40800000.
- Both ports request continuously (addr 0 and 4) → grants 0,1,0,1,…; rd_valid held high back-to-back, rd_port alternating 0,1 two cycles after the grants.
- Read addr 14 → without macro: lanes mem[14],mem[15],mem[0],mem[1], oob=0; with macro: lanes 2–3 = 0, oob=1 with rd_valid.
- Same cycle, write addr 0 with 9.0 and read addr 0 → lane 0 returns 1.0; next read returns 9.0. Mask 4'b0101 writes lanes 0 and 2 only.
- Grant at cycle t, reset at t+1 → no rd_valid at t+2; all outputs 0; memory data retained.
- No requests for 10 cycles → rd_valid, rd_data, rd_grant stay 0; ptr unchanged.
